// File: rtl/ex_stage_pipe_if.sv
// Bundle of decode-side, memory-side and result signals around the execute stage.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface ex_stage_pipe_if #(
   parameter int DW = 32,
   parameter int RW = 4,
   parameter int SW = 11
);
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [DW-1:0] data_a;
   logic [DW-1:0] data_b;
   logic [DW-1:0] imm;
   logic          imm_sel;
   logic [RW-1:0] rs_a;
   logic [RW-1:0] rs_b;
   logic [RW-1:0] rd;
   logic          reg_we;
   logic          set_flags;
   logic [3:0]    alu_op;
   logic [2:0]    br_cond;
   logic [DW-1:0] pc;
   logic [DW-1:0] br_imm;
   logic [SW-1:0] ctrl;
   logic [RW-1:0] mem_rd;
   logic          mem_we;
   logic [DW-1:0] mem_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] alu_result;
   logic [DW-1:0] write_data;
   logic [DW-1:0] new_pc;
   logic          br_taken;
   logic [RW-1:0] rd_out;
   logic          reg_we_out;
   logic [SW-1:0] ctrl_out;
   logic [3:0]    flags;

   modport master (
      output in_valid, flush, data_a, data_b, imm, imm_sel, rs_a, rs_b, rd,
             reg_we, set_flags, alu_op, br_cond, pc, br_imm, ctrl,
             mem_rd, mem_we, mem_data, out_ready,
      input  in_ready, out_valid, alu_result, write_data, new_pc, br_taken,
             rd_out, reg_we_out, ctrl_out, flags
   );

   modport slave (
      input  in_valid, flush, data_a, data_b, imm, imm_sel, rs_a, rs_b, rd,
             reg_we, set_flags, alu_op, br_cond, pc, br_imm, ctrl,
             mem_rd, mem_we, mem_data, out_ready,
      output in_ready, out_valid, alu_result, write_data, new_pc, br_taken,
             rd_out, reg_we_out, ctrl_out, flags
   );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready handshake, operand forwarding, NZCV flags and branch
// evaluation. Define EX_STAGE_MUL_EN to build the iterative shift-add multiplier (alu_op 10).
module ex_stage_pipe #(
   parameter int DW = 32,
   parameter int RW = 4,
   parameter int SW = 11
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_stage_pipe_if.slave bus
);
   localparam int SHW = $clog2(DW);

   logic [DW-1:0] alu_result_r;
   logic [DW-1:0] write_data_r;
   logic [DW-1:0] new_pc_r;
   logic          out_valid_r;
   logic          br_taken_r;
   logic [RW-1:0] rd_out_r;
   logic          reg_we_out_r;
   logic [SW-1:0] ctrl_out_r;
   logic [3:0]    flags_r;

   logic          out_free_s;
   logic          in_ready_s;
   logic          accept_s;
   logic          ex_hit_a_s;
   logic          mem_hit_a_s;
   logic          ex_hit_b_s;
   logic          mem_hit_b_s;
   logic [DW-1:0] op_a_s;
   logic [DW-1:0] op_b_s;
   logic [SHW-1:0] shamt_s;
   logic [DW:0]   sum_s;
   logic [DW:0]   diff_s;
   logic [DW-1:0] alu_res_s;
   logic          alu_c_s;
   logic          alu_v_s;
   logic [3:0]    flags_nxt_s;
   logic          ld_en_s;
   logic [DW-1:0] ld_res_s;
   logic [3:0]    ld_flags_s;
   logic          ld_sf_s;
   logic [RW-1:0] ld_rd_s;
   logic          ld_we_s;
   logic [SW-1:0] ld_ctrl_s;
   logic [DW-1:0] ld_wdata_s;
   logic [DW-1:0] ld_pc_s;
   logic          ld_br_s;

`ifdef EX_STAGE_MUL_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(DW - 1);

   state_t         state_r;
   logic [DW-1:0]  mcand_r;
   logic [DW-1:0]  mplier_r;
   logic [DW-1:0]  acc_r;
   logic [SHW-1:0] cnt_r;
   logic [RW-1:0]  p_rd_r;
   logic           p_we_r;
   logic           p_sf_r;
   logic [SW-1:0]  p_ctrl_r;
   logic [DW-1:0]  p_wdata_r;
   logic [DW-1:0]  p_pc_r;
   logic           p_br_r;
   logic           is_mul_s;
   logic           ld_mul_s;
   logic [DW-1:0]  mul_sum_s;
   logic [DW-1:0]  mul_res_s;
`endif

   function automatic logic br_eval(input logic [2:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         3'd0:    return 1'b0;
         3'd1:    return 1'b1;
         3'd2:    return z;
         3'd3:    return !z;
         3'd4:    return n ^ v;
         3'd5:    return !(n ^ v);
         3'd6:    return c;
         3'd7:    return !c;
         default: return 1'b0;
      endcase
   endfunction

   // Handshake: the stage only takes work when idle and the output slot can drain
   always_comb begin
      out_free_s = !out_valid_r || bus.out_ready;
`ifdef EX_STAGE_MUL_EN
      in_ready_s = (state_r == ST_IDLE) && out_free_s;
`else
      in_ready_s = out_free_s;
`endif
      accept_s   = bus.in_valid && in_ready_s && !bus.flush;
   end

   // Operand forwarding; the execute-stage result wins over the memory stage
   always_comb begin
      ex_hit_a_s  = (bus.rs_a != {RW{1'b0}}) && out_valid_r && reg_we_out_r && (rd_out_r == bus.rs_a);
      mem_hit_a_s = (bus.rs_a != {RW{1'b0}}) && bus.mem_we && (bus.mem_rd == bus.rs_a);
      ex_hit_b_s  = (bus.rs_b != {RW{1'b0}}) && out_valid_r && reg_we_out_r && (rd_out_r == bus.rs_b);
      mem_hit_b_s = (bus.rs_b != {RW{1'b0}}) && bus.mem_we && (bus.mem_rd == bus.rs_b);
      if (ex_hit_a_s) begin
         op_a_s = alu_result_r;
      end else if (mem_hit_a_s) begin
         op_a_s = bus.mem_data;
      end else begin
         op_a_s = bus.data_a;
      end
      if (bus.imm_sel) begin
         op_b_s = bus.imm;
      end else if (ex_hit_b_s) begin
         op_b_s = alu_result_r;
      end else if (mem_hit_b_s) begin
         op_b_s = bus.mem_data;
      end else begin
         op_b_s = bus.data_b;
      end
   end

   // Single-cycle ALU and the flag values it would produce
   always_comb begin
      shamt_s   = op_b_s[SHW-1:0];
      sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s};
      diff_s    = {1'b0, op_a_s} + {1'b0, ~op_b_s} + {{DW{1'b0}}, 1'b1};
      alu_res_s = {DW{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      case (bus.alu_op)
         4'd0: begin
            alu_res_s = sum_s[DW-1:0];
            alu_c_s   = sum_s[DW];
            alu_v_s   = (op_a_s[DW-1] == op_b_s[DW-1]) && (sum_s[DW-1] != op_a_s[DW-1]);
         end
         4'd1: begin
            alu_res_s = diff_s[DW-1:0];
            alu_c_s   = diff_s[DW];
            alu_v_s   = (op_a_s[DW-1] != op_b_s[DW-1]) && (diff_s[DW-1] != op_a_s[DW-1]);
         end
         4'd2:    alu_res_s = op_a_s & op_b_s;
         4'd3:    alu_res_s = op_a_s | op_b_s;
         4'd4:    alu_res_s = op_a_s ^ op_b_s;
         4'd5:    alu_res_s = op_a_s << shamt_s;
         4'd6:    alu_res_s = op_a_s >> shamt_s;
         4'd7:    alu_res_s = $unsigned($signed(op_a_s) >>> shamt_s);
         4'd8:    alu_res_s = {{(DW-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
         4'd9:    alu_res_s = op_b_s;
         default: alu_res_s = {DW{1'b0}};
      endcase
      flags_nxt_s = {alu_res_s[DW-1], (alu_res_s == {DW{1'b0}}), alu_c_s, alu_v_s};
   end

`ifdef EX_STAGE_MUL_EN
   // Multiplier datapath; a finished product waits in acc_r while in DONE
   always_comb begin
      is_mul_s  = (bus.alu_op == 4'd10);
      mul_sum_s = acc_r + (mplier_r[0] ? mcand_r : {DW{1'b0}});
      if (state_r == ST_DONE) begin
         mul_res_s = acc_r;
      end else begin
         mul_res_s = mul_sum_s;
      end
   end
`endif

   // Select what the output register loads this cycle: a fresh op or a finished product
   always_comb begin
      ld_en_s    = 1'b0;
      ld_res_s   = alu_res_s;
      ld_flags_s = flags_nxt_s;
      ld_sf_s    = bus.set_flags;
      ld_rd_s    = bus.rd;
      ld_we_s    = bus.reg_we;
      ld_ctrl_s  = bus.ctrl;
      ld_wdata_s = op_a_s;
      ld_pc_s    = bus.pc + bus.br_imm;
      ld_br_s    = br_eval(bus.br_cond, flags_r);
`ifdef EX_STAGE_MUL_EN
      ld_mul_s   = 1'b0;
      case (state_r)
         ST_IDLE: ld_en_s = accept_s && !is_mul_s;
         ST_MUL: begin
            ld_en_s  = (cnt_r == CNT_LAST) && out_free_s;
            ld_mul_s = 1'b1;
         end
         ST_DONE: begin
            ld_en_s  = out_free_s;
            ld_mul_s = 1'b1;
         end
         default: ld_en_s = 1'b0;
      endcase
      if (ld_mul_s) begin
         ld_res_s   = mul_res_s;
         ld_flags_s = {mul_res_s[DW-1], (mul_res_s == {DW{1'b0}}), 2'b00};
         ld_sf_s    = p_sf_r;
         ld_rd_s    = p_rd_r;
         ld_we_s    = p_we_r;
         ld_ctrl_s  = p_ctrl_r;
         ld_wdata_s = p_wdata_r;
         ld_pc_s    = p_pc_r;
         ld_br_s    = p_br_r;
      end else begin
         ld_res_s   = alu_res_s;
      end
`else
      ld_en_s    = accept_s;
`endif
   end

   // Output register, flags and multiplier sequencer; flush beats any accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         alu_result_r <= {DW{1'b0}};
         write_data_r <= {DW{1'b0}};
         new_pc_r     <= {DW{1'b0}};
         br_taken_r   <= 1'b0;
         rd_out_r     <= {RW{1'b0}};
         reg_we_out_r <= 1'b0;
         ctrl_out_r   <= {SW{1'b0}};
         flags_r      <= 4'b0000;
`ifdef EX_STAGE_MUL_EN
         state_r      <= ST_IDLE;
         mcand_r      <= {DW{1'b0}};
         mplier_r     <= {DW{1'b0}};
         acc_r        <= {DW{1'b0}};
         cnt_r        <= {SHW{1'b0}};
         p_rd_r       <= {RW{1'b0}};
         p_we_r       <= 1'b0;
         p_sf_r       <= 1'b0;
         p_ctrl_r     <= {SW{1'b0}};
         p_wdata_r    <= {DW{1'b0}};
         p_pc_r       <= {DW{1'b0}};
         p_br_r       <= 1'b0;
`endif
      end else if (bus.flush) begin
         out_valid_r  <= 1'b0;
         reg_we_out_r <= 1'b0;
         br_taken_r   <= 1'b0;
`ifdef EX_STAGE_MUL_EN
         state_r      <= ST_IDLE;
`endif
      end else begin
         if (ld_en_s) begin
            out_valid_r  <= 1'b1;
            alu_result_r <= ld_res_s;
            write_data_r <= ld_wdata_s;
            new_pc_r     <= ld_pc_s;
            br_taken_r   <= ld_br_s;
            rd_out_r     <= ld_rd_s;
            reg_we_out_r <= ld_we_s;
            ctrl_out_r   <= ld_ctrl_s;
            if (ld_sf_s) begin
               flags_r <= ld_flags_s;
            end
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
`ifdef EX_STAGE_MUL_EN
         case (state_r)
            ST_IDLE: begin
               if (accept_s && is_mul_s) begin
                  state_r   <= ST_MUL;
                  mcand_r   <= op_a_s;
                  mplier_r  <= op_b_s;
                  acc_r     <= {DW{1'b0}};
                  cnt_r     <= {SHW{1'b0}};
                  p_rd_r    <= bus.rd;
                  p_we_r    <= bus.reg_we;
                  p_sf_r    <= bus.set_flags;
                  p_ctrl_r  <= bus.ctrl;
                  p_wdata_r <= op_a_s;
                  p_pc_r    <= bus.pc + bus.br_imm;
                  p_br_r    <= br_eval(bus.br_cond, flags_r);
               end
            end
            ST_MUL: begin
               acc_r    <= mul_sum_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               cnt_r    <= cnt_r + SHW'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= out_free_s ? ST_IDLE : ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_free_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
`endif
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.alu_result = alu_result_r;
   assign bus.write_data = write_data_r;
   assign bus.new_pc     = new_pc_r;
   assign bus.br_taken   = br_taken_r;
   assign bus.rd_out     = rd_out_r;
   assign bus.reg_we_out = reg_we_out_r;
   assign bus.ctrl_out   = ctrl_out_r;
   assign bus.flags      = flags_r;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed self-checking bench for ex_stage_pipe; multiplier checks are built when
// EX_STAGE_MUL_EN is defined, otherwise alu_op 10 is checked as a zero-result op.
module tb_ex_stage_pipe;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   ex_stage_pipe_if #(.DW(32), .RW(4), .SW(11)) bus ();

   ex_stage_pipe #(.DW(32), .RW(4), .SW(11)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] dr, input logic we, input logic [31:0] da,
                        input logic [31:0] db, input logic isel, input logic [31:0] im,
                        input logic sf);
      bus.in_valid  = 1'b1;
      bus.alu_op    = op;
      bus.rs_a      = ra;
      bus.rs_b      = rb;
      bus.rd        = dr;
      bus.reg_we    = we;
      bus.data_a    = da;
      bus.data_b    = db;
      bus.imm_sel   = isel;
      bus.imm       = im;
      bus.set_flags = sf;
      bus.br_cond   = 3'd0;
      bus.pc        = 32'd0;
      bus.br_imm    = 32'd0;
      bus.ctrl      = 11'h5A5;
   endtask

   // ALU vector table: op, a, b, result, flags
   logic [3:0]  v_op  [13];
   logic [31:0] v_a   [13];
   logic [31:0] v_b   [13];
   logic [31:0] v_res [13];
   logic [3:0]  v_fl  [13];

   initial begin
      v_op[0]  = 4'd0;  v_a[0]  = 32'h7FFF_FFFF; v_b[0]  = 32'd1;         v_res[0]  = 32'h8000_0000; v_fl[0]  = 4'b1001;
      v_op[1]  = 4'd0;  v_a[1]  = 32'hFFFF_FFFF; v_b[1]  = 32'd1;         v_res[1]  = 32'h0000_0000; v_fl[1]  = 4'b0110;
      v_op[2]  = 4'd1;  v_a[2]  = 32'h8000_0000; v_b[2]  = 32'd1;         v_res[2]  = 32'h7FFF_FFFF; v_fl[2]  = 4'b0011;
      v_op[3]  = 4'd2;  v_a[3]  = 32'hF0F0_F0F0; v_b[3]  = 32'h0FF0_0FF0; v_res[3]  = 32'h00F0_00F0; v_fl[3]  = 4'b0000;
      v_op[4]  = 4'd3;  v_a[4]  = 32'h0000_0F00; v_b[4]  = 32'h0000_00F0; v_res[4]  = 32'h0000_0FF0; v_fl[4]  = 4'b0000;
      v_op[5]  = 4'd4;  v_a[5]  = 32'hFFFF_FFFF; v_b[5]  = 32'h0F0F_0F0F; v_res[5]  = 32'hF0F0_F0F0; v_fl[5]  = 4'b1000;
      v_op[6]  = 4'd5;  v_a[6]  = 32'd1;         v_b[6]  = 32'd33;        v_res[6]  = 32'd2;         v_fl[6]  = 4'b0000;
      v_op[7]  = 4'd6;  v_a[7]  = 32'h8000_0000; v_b[7]  = 32'd4;         v_res[7]  = 32'h0800_0000; v_fl[7]  = 4'b0000;
      v_op[8]  = 4'd7;  v_a[8]  = 32'h8000_0000; v_b[8]  = 32'd4;         v_res[8]  = 32'hF800_0000; v_fl[8]  = 4'b1000;
      v_op[9]  = 4'd8;  v_a[9]  = 32'hFFFF_FFFF; v_b[9]  = 32'd0;         v_res[9]  = 32'd1;         v_fl[9]  = 4'b0000;
      v_op[10] = 4'd8;  v_a[10] = 32'd0;         v_b[10] = 32'hFFFF_FFFF; v_res[10] = 32'd0;         v_fl[10] = 4'b0100;
      v_op[11] = 4'd9;  v_a[11] = 32'd5;         v_b[11] = 32'h1234_5678; v_res[11] = 32'h1234_5678; v_fl[11] = 4'b0000;
      v_op[12] = 4'd12; v_a[12] = 32'd7;         v_b[12] = 32'd9;         v_res[12] = 32'd0;         v_fl[12] = 4'b0100;
   end

   initial begin
      int cyc;
      int viol;
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.mem_rd    = 4'd0;
      bus.mem_we    = 1'b0;
      bus.mem_data  = 32'd0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_alu_result", bus.alu_result, 32'd0);
      check("rst_flags", bus.flags, 4'b0000);
      check("rst_new_pc", bus.new_pc, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", bus.in_ready, 1'b1);

      // ADD 5+7 into r3
      drive(4'd0, 4'd1, 4'd2, 4'd3, 1'b1, 32'd5, 32'd7, 1'b0, 32'd0, 1'b1);
      tick();
      check("add_valid", bus.out_valid, 1'b1);
      check("add_result", bus.alu_result, 32'd12);
      check("add_flags", bus.flags, 4'b0000);
      check("add_rd_out", bus.rd_out, 4'd3);
      check("add_ctrl_out", bus.ctrl_out, 11'h5A5);

      // SUB r3 (stale 0 in regfile) - imm 12, needs EX forward
      drive(4'd1, 4'd3, 4'd0, 4'd4, 1'b1, 32'd0, 32'd0, 1'b1, 32'd12, 1'b1);
      tick();
      check("fwd_ex_result", bus.alu_result, 32'd0);
      check("fwd_ex_flags", bus.flags, 4'b0110);
      check("fwd_ex_wdata", bus.write_data, 32'd12);

      // EX result 9 in r5 vs MEM 4 for r5: EX wins
      drive(4'd0, 4'd0, 4'd0, 4'd5, 1'b1, 32'd4, 32'd5, 1'b0, 32'd0, 1'b0);
      tick();
      drive(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0);
      bus.mem_rd = 4'd5; bus.mem_we = 1'b1; bus.mem_data = 32'd4;
      tick();
      check("fwd_prio", bus.alu_result, 32'd9);
      // r0 never forwarded
      drive(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 32'd33, 32'd0, 1'b1, 32'd0, 1'b0);
      bus.mem_rd = 4'd0;
      tick();
      check("fwd_r0", bus.alu_result, 32'd33);
      // MEM-only forward of A, result into r7
      drive(4'd0, 4'd6, 4'd0, 4'd7, 1'b1, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0);
      bus.mem_rd = 4'd6; bus.mem_data = 32'd77;
      tick();
      check("fwd_mem", bus.alu_result, 32'd77);
      // EX forward on operand B
      drive(4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
      bus.mem_we = 1'b0;
      tick();
      check("fwd_b", bus.alu_result, 32'd78);
      check("flags_hold", bus.flags, 4'b0110);

      // Backpressure for three cycles
      bus.out_ready = 1'b0;
      drive(4'd0, 4'd0, 4'd0, 4'd2, 1'b1, 32'd100, 32'd200, 1'b0, 32'd0, 1'b0);
      #1;
      check("stall_in_ready", bus.in_ready, 1'b0);
      repeat (3) tick();
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_result", bus.alu_result, 32'd78);
      bus.out_ready = 1'b1;
      #1;
      check("unstall_in_ready", bus.in_ready, 1'b1);
      tick();
      check("unstall_result", bus.alu_result, 32'd300);

      // ALU table
      for (int i = 0; i < 13; i++) begin
         drive(v_op[i], 4'd0, 4'd0, 4'd0, 1'b0, v_a[i], v_b[i], 1'b0, 32'd0, 1'b1);
         tick();
         check($sformatf("alu%0d_res", i), bus.alu_result, v_res[i]);
         check($sformatf("alu%0d_flags", i), bus.flags, v_fl[i]);
      end

      // SUB 3-5 then branch on N^V
      drive(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 32'd3, 32'd5, 1'b0, 32'd0, 1'b1);
      tick();
      check("sub_neg_res", bus.alu_result, 32'hFFFF_FFFE);
      check("sub_neg_flags", bus.flags, 4'b1000);
      drive(4'd9, 4'd0, 4'd0, 4'd1, 1'b1, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0);
      bus.br_cond = 3'd4; bus.pc = 32'h100; bus.br_imm = 32'h20;
      tick();
      check("br_lt_taken", bus.br_taken, 1'b1);
      check("br_new_pc", bus.new_pc, 32'h120);

      // Flush with an instruction presented: dropped, flags kept
      drive(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flush_valid", bus.out_valid, 1'b0);
      check("flush_we", bus.reg_we_out, 1'b0);
      check("flush_br", bus.br_taken, 1'b0);
      check("flush_flags", bus.flags, 4'b1000);

      // Branch uses flags from before the same-edge update
      drive(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1);
      bus.br_cond = 3'd2;
      tick();
      check("br_same_edge", bus.br_taken, 1'b0);
      check("br_same_flags", bus.flags, 4'b0110);
      drive(4'd9, 4'd0, 4'd0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      bus.br_cond = 3'd2; bus.pc = 32'hFFFF_FFF0; bus.br_imm = 32'h20;
      tick();
      check("br_z_taken", bus.br_taken, 1'b1);
      check("br_pc_wrap", bus.new_pc, 32'h10);

`ifdef EX_STAGE_MUL_EN
      drive(4'd10, 4'd0, 4'd0, 4'd3, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      cyc  = 0;
      viol = 0;
      while (!bus.out_valid && cyc < 40) begin
         if (bus.in_ready) viol++;
         tick();
         cyc++;
      end
      check("mul_latency", cyc, 32);
      check("mul_busy", viol, 0);
      check("mul_result", bus.alu_result, 32'hFFFF_FFFE);

      drive(4'd10, 4'd0, 4'd0, 4'd3, 1'b1, 32'd6, 32'd7, 1'b0, 32'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("mul_flush_valid", bus.out_valid, 1'b0);
      check("mul_flush_ready", bus.in_ready, 1'b1);
      viol = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) viol++;
      end
      check("mul_flush_nowrite", viol, 0);
`else
      drive(4'd10, 4'd0, 4'd0, 4'd0, 1'b0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("mul_off_valid", bus.out_valid, 1'b1);
      check("mul_off_result", bus.alu_result, 32'd0);
      check("mul_off_flags", bus.flags, 4'b0100);
      check("mul_off_ready", bus.in_ready, 1'b1);
`endif

      bus.in_valid = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
